// File: rtl/cond_bcast.sv
// Broadcast of the reduced global condition back to every PE, with per-PE valid/ack.
// Optional abort timer enabled by defining COND_BCAST_TIMEOUT_EN.
module cond_bcast #(
   parameter int NB_ROWS        = 4,
   parameter int NB_COLS        = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         Cond_Valid_i,
   input  logic                         Cond_i,
   output logic                         Cond_Ready_o,
   input  logic [NB_ROWS*NB_COLS-1:0]   Pe_Mask_i,
   output logic [NB_ROWS*NB_COLS-1:0]   Pe_Cond_o,
   output logic [NB_ROWS*NB_COLS-1:0]   Pe_Cond_Valid_o,
   input  logic [NB_ROWS*NB_COLS-1:0]   Pe_Cond_Ack_i,
   output logic                         Busy_o,
   output logic [7:0]                   Gen_Count_o,
   output logic                         Timeout_o
);

   localparam int N = NB_ROWS * NB_COLS;

   typedef enum logic {IDLE = 1'b0, BCAST = 1'b1} state_t;

   state_t         state;
   logic           cond_q;
   logic [N-1:0]   pending;
   logic [7:0]     gen_cnt;
   logic [N-1:0]   pending_nxt;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_cycles
      $error("cond_bcast: TIMEOUT_CYCLES must be in 1..65535");
   end

   assign pending_nxt = pending & ~Pe_Cond_Ack_i;

`ifdef COND_BCAST_TIMEOUT_EN
   // Timer value seen during the last permitted BCAST cycle.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] timer;
   logic        timeout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cond_q    <= 1'b0;
         pending   <= '0;
         gen_cnt   <= '0;
         timer     <= '0;
         timeout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Cond_Valid_i) begin
                  cond_q  <= Cond_i;
                  pending <= Pe_Mask_i;
                  timer   <= '0;
                  if (Pe_Mask_i != '0) state <= BCAST;
                  else                 gen_cnt <= gen_cnt + 8'd1;
               end
            end
            BCAST: begin
               // Normal completion wins over an abort on the same edge.
               if (pending_nxt == '0) begin
                  pending <= '0;
                  state   <= IDLE;
                  gen_cnt <= gen_cnt + 8'd1;
               end else if (timer == TMO_LAST) begin
                  pending   <= '0;
                  state     <= IDLE;
                  timeout_q <= 1'b1;
               end else begin
                  pending <= pending_nxt;
                  timer   <= timer + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign Timeout_o = timeout_q;
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cond_q  <= 1'b0;
         pending <= '0;
         gen_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Cond_Valid_i) begin
                  cond_q  <= Cond_i;
                  pending <= Pe_Mask_i;
                  if (Pe_Mask_i != '0) state <= BCAST;
                  else                 gen_cnt <= gen_cnt + 8'd1;
               end
            end
            BCAST: begin
               pending <= pending_nxt;
               if (pending_nxt == '0) begin
                  state   <= IDLE;
                  gen_cnt <= gen_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign Timeout_o = 1'b0;
`endif

   assign Pe_Cond_o       = {N{cond_q}};
   assign Pe_Cond_Valid_o = pending;
   assign Cond_Ready_o    = (state == IDLE);
   assign Busy_o          = (state == BCAST);
   assign Gen_Count_o     = gen_cnt;

endmodule

// File: tb/tb_cond_bcast.sv
// Directed bench for cond_bcast; timeout scenario runs when COND_BCAST_TIMEOUT_EN is defined.
module tb_cond_bcast;

   logic        clk = 1'b0;
   logic        rst;
   logic        Cond_Valid_i;
   logic        Cond_i;
   logic        Cond_Ready_o;
   logic [15:0] Pe_Mask_i;
   logic [15:0] Pe_Cond_o;
   logic [15:0] Pe_Cond_Valid_o;
   logic [15:0] Pe_Cond_Ack_i;
   logic        Busy_o;
   logic [7:0]  Gen_Count_o;
   logic        Timeout_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

`ifdef COND_BCAST_TIMEOUT_EN
   localparam int TMO = 10;
`else
   localparam int TMO = 255;
`endif

   cond_bcast #(.NB_ROWS(4), .NB_COLS(4), .TIMEOUT_CYCLES(TMO)) dut (
      .clk             (clk),
      .rst             (rst),
      .Cond_Valid_i    (Cond_Valid_i),
      .Cond_i          (Cond_i),
      .Cond_Ready_o    (Cond_Ready_o),
      .Pe_Mask_i       (Pe_Mask_i),
      .Pe_Cond_o       (Pe_Cond_o),
      .Pe_Cond_Valid_o (Pe_Cond_Valid_o),
      .Pe_Cond_Ack_i   (Pe_Cond_Ack_i),
      .Busy_o          (Busy_o),
      .Gen_Count_o     (Gen_Count_o),
      .Timeout_o       (Timeout_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] exp_pend;

   initial begin
      rst           = 1'b1;
      Cond_Valid_i  = 1'($urandom_range(0, 1));
      Cond_i        = 1'($urandom_range(0, 1));
      Pe_Mask_i     = 16'($urandom);
      Pe_Cond_Ack_i = 16'($urandom);
      tick();
      tick();
      chk("rst_ready", 32'(Cond_Ready_o), 32'd1);
      chk("rst_busy", 32'(Busy_o), 32'd0);
      chk("rst_valid", 32'(Pe_Cond_Valid_o), 32'h0);
      chk("rst_cond", 32'(Pe_Cond_o), 32'h0);
      chk("rst_gen", 32'(Gen_Count_o), 32'd0);
      chk("rst_tmo", 32'(Timeout_o), 32'd0);

      rst           = 1'b0;
      Cond_Valid_i  = 1'b0;
      Pe_Cond_Ack_i = '0;
      tick();

      // Full broadcast, one ack per cycle
      Cond_Valid_i = 1'b1; Cond_i = 1'b1; Pe_Mask_i = 16'hFFFF;
      tick();
      Cond_Valid_i = 1'b0;
      chk("full_busy", 32'(Busy_o), 32'd1);
      chk("full_ready", 32'(Cond_Ready_o), 32'd0);
      chk("full_valid0", 32'(Pe_Cond_Valid_o), 32'hFFFF);
      exp_pend = 16'hFFFF;
      for (int i = 0; i < 16; i++) begin
         Pe_Cond_Ack_i = 16'(1) << i;
         tick();
         exp_pend = exp_pend & ~(16'(1) << i);
         chk($sformatf("full_valid_%0d", i), 32'(Pe_Cond_Valid_o), 32'(exp_pend));
         chk($sformatf("full_cond_%0d", i), 32'(Pe_Cond_o), 32'hFFFF);
         chk($sformatf("full_busy_%0d", i), 32'(Busy_o), (i < 15) ? 32'd1 : 32'd0);
      end
      Pe_Cond_Ack_i = '0;
      chk("full_gen", 32'(Gen_Count_o), 32'd1);
      chk("full_ready_end", 32'(Cond_Ready_o), 32'd1);

      // Partial mask with stray acks
      Cond_Valid_i = 1'b1; Cond_i = 1'b0; Pe_Mask_i = 16'h00A5;
      tick();
      Cond_Valid_i = 1'b0;
      chk("part_valid", 32'(Pe_Cond_Valid_o), 32'h00A5);
      chk("part_cond", 32'(Pe_Cond_o), 32'h0);
      Pe_Cond_Ack_i = 16'hFF5A;
      tick();
      chk("part_stray_valid", 32'(Pe_Cond_Valid_o), 32'h00A5);
      chk("part_stray_busy", 32'(Busy_o), 32'd1);
      Pe_Cond_Ack_i = 16'h00A5;
      tick();
      Pe_Cond_Ack_i = '0;
      chk("part_done_busy", 32'(Busy_o), 32'd0);
      chk("part_done_valid", 32'(Pe_Cond_Valid_o), 32'h0);
      chk("part_done_cond", 32'(Pe_Cond_o), 32'h0);
      chk("part_gen", 32'(Gen_Count_o), 32'd2);

      // Empty mask completes immediately
      Cond_Valid_i = 1'b1; Cond_i = 1'b1; Pe_Mask_i = 16'h0000;
      tick();
      Cond_Valid_i = 1'b0;
      chk("empty_busy", 32'(Busy_o), 32'd0);
      chk("empty_ready", 32'(Cond_Ready_o), 32'd1);
      chk("empty_valid", 32'(Pe_Cond_Valid_o), 32'h0);
      chk("empty_gen", 32'(Gen_Count_o), 32'd3);

      // Valid held, inputs changed during BCAST, plus a long ack stall
      Cond_Valid_i = 1'b1; Cond_i = 1'b1; Pe_Mask_i = 16'h0003;
      tick();
      Cond_i = 1'b0; Pe_Mask_i = 16'hFFFF;
      tick();
      chk("hold_cond", 32'(Pe_Cond_o), 32'hFFFF);
      chk("hold_valid", 32'(Pe_Cond_Valid_o), 32'h0003);
      Pe_Cond_Ack_i = 16'h0001;
      tick();
      chk("hold_valid1", 32'(Pe_Cond_Valid_o), 32'h0002);
      Pe_Cond_Ack_i = 16'h0000;
      for (int i = 0; i < 5; i++) tick();
      chk("hold_stall_busy", 32'(Busy_o), 32'd1);
      Pe_Cond_Ack_i = 16'h0002;
      tick();
      Pe_Cond_Ack_i = '0;
      chk("hold_done_busy", 32'(Busy_o), 32'd0);
      chk("hold_no_b2b", 32'(Pe_Cond_Valid_o), 32'h0);
      chk("hold_gen", 32'(Gen_Count_o), 32'd4);
      tick();
      chk("hold_recap_cond", 32'(Pe_Cond_o), 32'h0);
      chk("hold_recap_valid", 32'(Pe_Cond_Valid_o), 32'hFFFF);
      Cond_Valid_i = 1'b0;
      Pe_Cond_Ack_i = 16'hFFFF;
      tick();
      Pe_Cond_Ack_i = '0;
      chk("hold_gen2", 32'(Gen_Count_o), 32'd5);

      // Wrap the generation counter with empty broadcasts
      Cond_Valid_i = 1'b1; Pe_Mask_i = 16'h0000;
      for (int i = 0; i < 250; i++) tick();
      chk("wrap_255", 32'(Gen_Count_o), 32'd255);
      tick();
      Cond_Valid_i = 1'b0;
      chk("wrap_0", 32'(Gen_Count_o), 32'd0);
      chk("wrap_busy", 32'(Busy_o), 32'd0);

`ifdef COND_BCAST_TIMEOUT_EN
      // Abort after TMO BCAST cycles when PE1 never acks
      Cond_Valid_i = 1'b1; Cond_i = 1'b1; Pe_Mask_i = 16'h0003;
      tick();
      Cond_Valid_i = 1'b0;
      Pe_Cond_Ack_i = 16'h0001;
      tick();
      Pe_Cond_Ack_i = '0;
      for (int i = 0; i < TMO - 2; i++) tick();
      chk("tmo_pre_busy", 32'(Busy_o), 32'd1);
      chk("tmo_pre_valid", 32'(Pe_Cond_Valid_o), 32'h0002);
      chk("tmo_pre_flag", 32'(Timeout_o), 32'd0);
      tick();
      chk("tmo_busy", 32'(Busy_o), 32'd0);
      chk("tmo_valid", 32'(Pe_Cond_Valid_o), 32'h0);
      chk("tmo_flag", 32'(Timeout_o), 32'd1);
      chk("tmo_gen", 32'(Gen_Count_o), 32'd0);
      Cond_Valid_i = 1'b1; Pe_Mask_i = 16'h0001;
      tick();
      Cond_Valid_i = 1'b0;
      Pe_Cond_Ack_i = 16'h0001;
      tick();
      Pe_Cond_Ack_i = '0;
      chk("tmo_after_gen", 32'(Gen_Count_o), 32'd1);
      chk("tmo_sticky", 32'(Timeout_o), 32'd1);
`else
      chk("no_tmo_flag", 32'(Timeout_o), 32'd0);
`endif

      rst = 1'b1;
      tick();
      chk("rst2_tmo", 32'(Timeout_o), 32'd0);
      chk("rst2_gen", 32'(Gen_Count_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
